// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - command/response sequencer around the 4-bit ALU
// Optional ALU_SEQ_STATS_EN adds handshake and stall counters.
module alu_seq_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_zero,
  output logic       rsp_ovf,
`ifdef ALU_SEQ_STATS_EN
  input  logic       stat_clr,
  output logic [7:0] stat_ops,
  output logic [7:0] stat_stall,
`endif
  output logic       busy
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("alu_seq_ctrl: WAIT_CYCLES must be within 1..15");
    end
  endgenerate

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [3:0] data_q, data_d;
  logic       zero_q, zero_d, ovf_q, ovf_d;

  logic [3:0] sum, diff, alu_data;
  logic       alu_ovf;

  // ALU datapath, fed only from the latched operands
  always_comb begin
    sum      = a_q + b_q;
    diff     = a_q - b_q;
    alu_ovf  = 1'b0;
    alu_data = 4'h0;
    case (op_q)
      3'd0: begin
        alu_data = sum;
        alu_ovf  = (a_q[3] == b_q[3]) && (sum[3] != a_q[3]);
      end
      3'd1: begin
        alu_data = diff;
        alu_ovf  = (a_q[3] != b_q[3]) && (diff[3] != a_q[3]);
      end
      3'd2: alu_data = ~a_q;
      3'd3: alu_data = a_q & b_q;
      3'd4: alu_data = a_q | b_q;
      3'd5: alu_data = a_q ^ b_q;
      3'd6: alu_data = {3'b000, $signed(a_q) < $signed(b_q)};
      default: alu_data = {3'b000, a_q == b_q};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'h0;
      op_q    <= 3'h0;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      data_q  <= 4'h0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          cnt_d   = WAIT_LD;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd1) begin
          data_d  = alu_data;
          zero_d  = (alu_data == 4'h0);
          ovf_d   = alu_ovf;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    rsp_data  = data_q;
    rsp_zero  = zero_q;
    rsp_ovf   = ovf_q;
  end

`ifdef ALU_SEQ_STATS_EN
  logic [7:0] ops_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q   <= 8'h00;
      stall_q <= 8'h00;
    end else if (stat_clr) begin
      ops_q   <= 8'h00;
      stall_q <= 8'h00;
    end else begin
      if (rsp_valid && rsp_ready && ops_q != 8'hFF)    ops_q   <= ops_q + 8'd1;
      if (rsp_valid && !rsp_ready && stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
    end
  end

  assign stat_ops   = ops_q;
  assign stat_stall = stall_q;
`endif

endmodule
